// File: rtl/mmcm_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// mmcm_reconfig_ctrl
//
// Brings an MMCM out of reset, waits for lock (with bounded retries), and
// then serves single DRP read/write requests from a level-style requester.
// A DRP write holds the MMCM in reset across the transaction and is followed
// by a full reset/relock sequence. Any unrecoverable condition (lock never
// achieved, DRDY never returned) parks the controller in a sticky fault
// state until RST_N is asserted.
//
// Optional feature macro: MMCM_CTRL_LOSS_RECOVERY_EN
//   defined   : lock loss while idle restarts the reset/relock sequence
//   undefined : lock loss while idle is a fault
//
// Parameters
//   RST_CYCLES   cycles MMCM_RST is held high per reset sequence
//   LOCK_TIMEOUT cycles allowed for MMCM_LOCKED to rise
//   DRP_TIMEOUT  cycles allowed for DRDY, counted from the DEN cycle
//   MAX_RETRY    lock attempts before declaring a fault
//
// Ports
//   CLK, RST_N            clock (also DRP DCLK), async active-low reset
//   CFG_REQ/WE/ADDR/WDATA request side: level request, direction, address, data
//   CFG_ACK, CFG_RDATA    one-cycle completion pulse, read data (held)
//   MMCM_RST, MMCM_LOCKED MMCM reset out, lock in
//   DADDR, DI, DEN, DWE   DRP request outputs
//   DO, DRDY              DRP response inputs
//   READY                 locked and idle
//   FAULT                 sticky fault flag
// ---------------------------------------------------------------------------
module mmcm_reconfig_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int DRP_TIMEOUT  = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CFG_REQ,
  input  logic        CFG_WE,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_WDATA,
  output logic        CFG_ACK,
  output logic [15:0] CFG_RDATA,
  output logic        MMCM_RST,
  input  logic        MMCM_LOCKED,
  output logic [6:0]  DADDR,
  output logic [15:0] DI,
  output logic        DEN,
  output logic        DWE,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        READY,
  output logic        FAULT
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > DRP_TIMEOUT) ? CNT_MAX_A : DRP_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RTY_W     = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_DRP_ISSUE = 3'd3,
    ST_DRP_WAIT  = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              cnt_clr;
  logic              load;
  logic              done;
  logic              we_q;
  logic [6:0]        addr_q;
  logic [15:0]       wdata_q;
  logic              ack_q;
  logic [15:0]       rdata_q;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RTY_W-1:0] rty_inc(input logic [RTY_W-1:0] v);
    return (v >= RTY_MAX) ? v : v + RTY_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_clr = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q >= RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (MMCM_LOCKED) begin
          state_d = ST_IDLE;
          retry_d = '0;
          cnt_clr = 1'b1;
        end else if (cnt_q >= LOCK_LAST) begin
          retry_d = rty_inc(retry_q);
          cnt_clr = 1'b1;
          state_d = (rty_inc(retry_q) >= RTY_MAX) ? ST_FAULT : ST_RST_HOLD;
        end
      end
      ST_IDLE: begin
        if (!MMCM_LOCKED) begin
          cnt_clr = 1'b1;
`ifdef MMCM_CTRL_LOSS_RECOVERY_EN
          retry_d = '0;
          state_d = ST_RST_HOLD;
`else
          state_d = ST_FAULT;
`endif
        end else if (CFG_REQ && !ack_q) begin
          // While the ACK pulse is visible the requester has not yet had a
          // chance to drop its level request, so it is not a new request.
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_DRP_ISSUE;
        end
      end
      ST_DRP_ISSUE: begin
        // Counter keeps running so the DRDY timeout is measured from DEN.
        state_d = ST_DRP_WAIT;
      end
      ST_DRP_WAIT: begin
        if (DRDY) begin
          done    = 1'b1;
          cnt_clr = 1'b1;
          state_d = we_q ? ST_RST_HOLD : ST_IDLE;
        end else if (cnt_q >= DRP_LAST) begin
          cnt_clr = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_inc(cnt_q);
      retry_q <= retry_d;
      ack_q   <= done;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (load) begin
        we_q    <= CFG_WE;
        addr_q  <= CFG_ADDR;
        wdata_q <= CFG_WDATA;
      end
      if (done && !we_q) begin
        rdata_q <= DO;
      end
    end
  end

  // A write keeps the MMCM in reset for the whole DRP transaction.
  assign MMCM_RST  = (state_q == ST_RST_HOLD) || (state_q == ST_FAULT) ||
                     (((state_q == ST_DRP_ISSUE) || (state_q == ST_DRP_WAIT)) && we_q);
  assign DEN       = (state_q == ST_DRP_ISSUE);
  assign DWE       = (state_q == ST_DRP_ISSUE) && we_q;
  assign DADDR     = addr_q;
  assign DI        = wdata_q;
  assign READY     = (state_q == ST_IDLE) && MMCM_LOCKED;
  assign FAULT     = (state_q == ST_FAULT);
  assign CFG_ACK   = ack_q;
  assign CFG_RDATA = rdata_q;

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmcm_reconfig_ctrl
//
// Self-checking bench for mmcm_reconfig_ctrl with default parameters.
// Requests are pushed to an expectation queue when driven; the DRP strobe is
// checked against the queue head and the entry is popped on CFG_ACK.
// Honours MMCM_CTRL_LOSS_RECOVERY_EN for the lock-loss scenario.
// ---------------------------------------------------------------------------
module tb_mmcm_reconfig_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CFG_REQ;
  logic        CFG_WE;
  logic [6:0]  CFG_ADDR;
  logic [15:0] CFG_WDATA;
  logic        CFG_ACK;
  logic [15:0] CFG_RDATA;
  logic        MMCM_RST;
  logic        MMCM_LOCKED;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic        DEN;
  logic        DWE;
  logic [15:0] DO;
  logic        DRDY;
  logic        READY;
  logic        FAULT;

  mmcm_reconfig_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CFG_REQ    (CFG_REQ),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_WDATA  (CFG_WDATA),
    .CFG_ACK    (CFG_ACK),
    .CFG_RDATA  (CFG_RDATA),
    .MMCM_RST   (MMCM_RST),
    .MMCM_LOCKED(MMCM_LOCKED),
    .DADDR      (DADDR),
    .DI         (DI),
    .DEN        (DEN),
    .DWE        (DWE),
    .DO         (DO),
    .DRDY       (DRDY),
    .READY      (READY),
    .FAULT      (FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_rd = '0;

  int   den_cnt = 0;
  int   ack_cnt = 0;
  logic den_prev = 1'b0;
  logic den_twice = 1'b0;

  always @(posedge CLK) begin
    if (DEN && den_prev) den_twice <= 1'b1;
    den_prev <= DEN;
    if (DEN) den_cnt <= den_cnt + 1;
    if (CFG_ACK) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    RST_N       = 1'b0;
    CFG_REQ     = 1'b0;
    CFG_WE      = 1'b0;
    CFG_ADDR    = '0;
    CFG_WDATA   = '0;
    MMCM_LOCKED = 1'b0;
    DO          = '0;
    DRDY        = 1'b0;
    last_rd     = '0;
    exp_q.delete();
    repeat (3) tick;
  endtask

  // Counts samples until MMCM_RST falls, then raises lock 5 cycles later.
  task automatic bring_up(input string tag, input int exp_hold);
    int n;
    n = 0;
    MMCM_LOCKED = 1'b0;
    while (MMCM_RST !== 1'b0 && n < 100) begin
      tick;
      n++;
    end
    check_eq({tag, "_rst_hold"}, n, exp_hold);
    repeat (4) tick;
    MMCM_LOCKED = 1'b1;
    check_eq({tag, "_ready_pre"}, READY, 1'b0);
    tick;
    check_eq({tag, "_ready"}, READY, 1'b1);
  endtask

  // One DRP transaction; lat >= 1 is the number of cycles from DEN to DRDY.
  task automatic drp_xact(input string tag, input logic we, input logic [6:0] addr,
                          input logic [15:0] wdata, input logic [15:0] dov, input int lat);
    exp_t e;
    int   n;
    int   den0;
    int   ack0;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? last_rd : dov;
    exp_q.push_back(e);
    den0 = den_cnt;
    ack0 = ack_cnt;
    CFG_REQ   = 1'b1;
    CFG_WE    = we;
    CFG_ADDR  = addr;
    CFG_WDATA = wdata;
    n = 0;
    while (DEN !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check_eq({tag, "_den"}, DEN, 1'b1);
    check_eq({tag, "_dwe"}, DWE, exp_q[0].we);
    check_eq({tag, "_daddr"}, DADDR, exp_q[0].addr);
    if (we) check_eq({tag, "_di"}, DI, exp_q[0].wdata);
    check_eq({tag, "_mmcm_rst"}, MMCM_RST, we);
    // The MMCM loses lock while it is held in reset by a write.
    if (we) MMCM_LOCKED = 1'b0;
    repeat (lat) tick;
    DRDY = 1'b1;
    DO   = dov;
    tick;
    DRDY = 1'b0;
    DO   = 16'($urandom);
    n = 0;
    while (CFG_ACK !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check_eq({tag, "_ack"}, CFG_ACK, 1'b1);
    CFG_REQ = 1'b0;
    e = exp_q.pop_front();
    check_eq({tag, "_rdata"}, CFG_RDATA, e.rdata);
    if (!we) last_rd = dov;
    check_eq({tag, "_rst_at_ack"}, MMCM_RST, we);
    tick;
    check_eq({tag, "_ack_pulse"}, CFG_ACK, 1'b0);
    check_eq({tag, "_ack_count"}, ack_cnt - ack0, 1);
    check_eq({tag, "_den_count"}, den_cnt - den0, 1);
  endtask

  initial begin
    int   n;
    int   falls;
    int   ack0;
    int   den0;
    logic prev;

    // Reset state
    do_reset;
    check_eq("rst_mmcm_rst", MMCM_RST, 1'b1);
    check_eq("rst_den", DEN, 1'b0);
    check_eq("rst_dwe", DWE, 1'b0);
    check_eq("rst_daddr", DADDR, 7'h00);
    check_eq("rst_di", DI, 16'h0000);
    check_eq("rst_ack", CFG_ACK, 1'b0);
    check_eq("rst_rdata", CFG_RDATA, 16'h0000);
    check_eq("rst_ready", READY, 1'b0);
    check_eq("rst_fault", FAULT, 1'b0);

    RST_N = 1'b1;
    bring_up("init", 16);

    // Stray DRDY while idle must not complete anything.
    ack0 = ack_cnt;
    DRDY = 1'b1;
    DO   = 16'hDEAD;
    tick;
    DRDY = 1'b0;
    repeat (2) tick;
    check_eq("stray_drdy_ack", ack_cnt - ack0, 0);
    check_eq("stray_drdy_rdata", CFG_RDATA, 16'h0000);

    drp_xact("rd08", 1'b0, 7'h08, 16'h5555, 16'h1234, 3);
    drp_xact("wr14", 1'b1, 7'h14, 16'hABCD, 16'h0F0F, 2);
    // One hold cycle already elapsed at the sample after the ACK pulse.
    bring_up("relock", 15);
    drp_xact("rd2a", 1'b0, 7'h2A, 16'h0000, 16'h5A5A, 1);
    check_eq("rdata_hold", CFG_RDATA, 16'h5A5A);

    // Reset in the middle of a read abandons it.
    ack0 = ack_cnt;
    CFG_REQ  = 1'b1;
    CFG_WE   = 1'b0;
    CFG_ADDR = 7'h33;
    n = 0;
    while (DEN !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check_eq("midrst_den", DEN, 1'b1);
    tick;
    RST_N = 1'b0;
    #1;
    check_eq("midrst_mmcm_rst", MMCM_RST, 1'b1);
    check_eq("midrst_den_low", DEN, 1'b0);
    check_eq("midrst_rdata", CFG_RDATA, 16'h0000);
    DRDY = 1'b1;
    DO   = 16'hFFFF;
    repeat (2) tick;
    DRDY    = 1'b0;
    CFG_REQ = 1'b0;
    last_rd = '0;
    RST_N   = 1'b1;
    bring_up("midrst", 16);
    check_eq("midrst_no_ack", ack_cnt - ack0, 0);

    // Lock loss while idle.
    MMCM_LOCKED = 1'b0;
    tick;
    check_eq("loss_ready", READY, 1'b0);
    check_eq("loss_mmcm_rst", MMCM_RST, 1'b1);
`ifdef MMCM_CTRL_LOSS_RECOVERY_EN
    check_eq("loss_fault", FAULT, 1'b0);
    bring_up("loss_relock", 16);
`else
    check_eq("loss_fault", FAULT, 1'b1);
    repeat (5) tick;
    check_eq("loss_fault_sticky", FAULT, 1'b1);
    do_reset;
    RST_N = 1'b1;
    bring_up("loss_reinit", 16);
`endif

    // DRDY never returns.
    ack0 = ack_cnt;
    den0 = den_cnt;
    CFG_REQ  = 1'b1;
    CFG_WE   = 1'b0;
    CFG_ADDR = 7'h01;
    n = 0;
    while (DEN !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check_eq("drpto_den", DEN, 1'b1);
    n = 0;
    while (FAULT !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    check_eq("drpto_cycles", n, 64);
    MMCM_LOCKED = 1'b1;
    repeat (5) tick;
    check_eq("drpto_fault", FAULT, 1'b1);
    check_eq("drpto_mmcm_rst", MMCM_RST, 1'b1);
    check_eq("drpto_ready", READY, 1'b0);
    check_eq("drpto_den_low", DEN, 1'b0);
    check_eq("drpto_den_count", den_cnt - den0, 1);
    check_eq("drpto_no_ack", ack_cnt - ack0, 0);

    // Lock never achieved: three reset/timeout rounds, then fault.
    do_reset;
    RST_N = 1'b1;
    n = 0;
    falls = 0;
    prev = MMCM_RST;
    while (FAULT !== 1'b1 && n < 5000) begin
      tick;
      n++;
      if (prev && !MMCM_RST) falls++;
      prev = MMCM_RST;
    end
    check_eq("lockto_cycles", n, 3 * (16 + 1024));
    check_eq("lockto_rst_falls", falls, 3);
    repeat (50) tick;
    check_eq("lockto_fault", FAULT, 1'b1);
    check_eq("lockto_mmcm_rst", MMCM_RST, 1'b1);
    check_eq("lockto_ready", READY, 1'b0);

    check_eq("den_never_twice", den_twice, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
